// File: rtl/conv_a1_pkg.sv
// Shared constants, address widths and FSM state encoding for the ConvA1 controller.
package conv_a1_pkg;

    localparam int unsigned IFM_SIZE          = 32;
    localparam int unsigned KERNAL_SIZE       = 5;
    localparam int unsigned NUMBER_OF_FILTERS = 6;
    localparam int unsigned CONV_LATENCY      = 4;

    localparam int unsigned IFM_SIZE_NEXT = IFM_SIZE - KERNAL_SIZE + 1;
    localparam int unsigned NUMBER_OF_WM  = KERNAL_SIZE * KERNAL_SIZE;
    // memory read + conv unit + partial_sum/full_sum registers
    localparam int unsigned PIPE_LATENCY  = 1 + CONV_LATENCY + 2;
    localparam int unsigned IFM_PIXELS    = IFM_SIZE * IFM_SIZE;

    localparam int unsigned IFM_AW = $clog2(IFM_PIXELS);
    localparam int unsigned WM_AW  = $clog2(NUMBER_OF_FILTERS * NUMBER_OF_WM);
    localparam int unsigned BM_AW  = $clog2(NUMBER_OF_FILTERS);
    localparam int unsigned OFM_AW = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT);
    localparam int unsigned CNT_W  = IFM_AW;
    localparam int unsigned TAG_W  = 1 + OFM_AW;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/conv_a1_controller_if.sv
// Control/strobe bundle between the ConvA1 sequencer (master) and datapath/RISC-V side (slave).
interface conv_a1_controller_if;
    import conv_a1_pkg::*;

    logic                         start;
    logic                         busy;
    logic                         done;
    logic                         ifm_enable_read_current;
    logic [IFM_AW-1:0]            ifm_address_read_current;
    logic                         fifo_enable;
    logic                         conv_enable;
    logic                         wm_addr_sel;
    logic                         wm_enable_read;
    logic [WM_AW-1:0]             wm_address_read_current;
    logic                         wm_fifo_enable;
    logic                         bm_addr_sel;
    logic                         bm_enable_read;
    logic [BM_AW-1:0]             bm_address_read_current;
    logic [NUMBER_OF_FILTERS-1:0] ofm_enable_write;
    logic [OFM_AW-1:0]            ofm_address_write;

    modport master (
        input  start,
        output busy, done,
        output ifm_enable_read_current, ifm_address_read_current,
        output fifo_enable, conv_enable,
        output wm_addr_sel, wm_enable_read, wm_address_read_current, wm_fifo_enable,
        output bm_addr_sel, bm_enable_read, bm_address_read_current,
        output ofm_enable_write, ofm_address_write
    );

    modport slave (
        output start,
        input  busy, done,
        input  ifm_enable_read_current, ifm_address_read_current,
        input  fifo_enable, conv_enable,
        input  wm_addr_sel, wm_enable_read, wm_address_read_current, wm_fifo_enable,
        input  bm_addr_sel, bm_enable_read, bm_address_read_current,
        input  ofm_enable_write, ofm_address_write
    );

endinterface

// File: rtl/conv_a1_controller_tag_delay_line.sv
// Fixed-depth shift register with synchronous clear; aligns OFM write tags to datapath latency.
module tag_delay_line #(
    parameter int unsigned DEPTH = 7,
    parameter int unsigned WIDTH = 11
) (
    input  logic             clk,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk) begin
        if (i_clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/conv_a1_controller.sv
// ConvA1 sequencer: per filter, preload weights from WM, stream the IFM raster,
// then drain the tag pipeline so OFM writes line up with datapath latency.
module conv_a1_controller
    import conv_a1_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    conv_a1_controller_if.master bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [BM_AW-1:0] r_filter;
    logic [BM_AW-1:0] w_filter_nxt;

    logic             r_wm_fifo_en;
    logic             r_fifo_en;

    logic             w_busy;
    logic             w_done;
    logic             w_ifm_en;
    logic [IFM_AW-1:0] w_ifm_addr;
    logic             w_wm_en;
    logic [WM_AW-1:0] w_wm_addr;
    logic             w_bm_en;

    logic [CNT_W-1:0]  w_row;
    logic [CNT_W-1:0]  w_col;
    logic              w_tag_valid;
    logic [OFM_AW-1:0] w_tag_addr;
    logic [TAG_W-1:0]  w_dl_out;
    logic              w_dl_valid;
    logic [OFM_AW-1:0] w_dl_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_filter     <= '0;
            r_wm_fifo_en <= 1'b0;
            r_fifo_en    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_filter     <= w_filter_nxt;
            r_wm_fifo_en <= w_wm_en;
            r_fifo_en    <= w_ifm_en;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_filter_nxt = r_filter;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        w_ifm_en     = 1'b0;
        w_ifm_addr   = '0;
        w_wm_en      = 1'b0;
        w_wm_addr    = '0;
        w_bm_en      = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_state_nxt  = LOAD_W;
                    w_cnt_nxt    = '0;
                    w_filter_nxt = '0;
                end
            end
            LOAD_W: begin
                w_wm_en   = 1'b1;
                w_wm_addr = WM_AW'(r_filter) * WM_AW'(NUMBER_OF_WM) + WM_AW'(r_cnt);
                if (r_cnt == CNT_W'(NUMBER_OF_WM - 1)) begin
                    w_state_nxt = STREAM;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            STREAM: begin
                w_ifm_en   = 1'b1;
                w_ifm_addr = IFM_AW'(r_cnt);
                w_bm_en    = 1'b1;
                if (r_cnt == CNT_W'(IFM_PIXELS - 1)) begin
                    w_state_nxt = DRAIN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            DRAIN: begin
                w_bm_en = 1'b1;
                if (r_cnt == CNT_W'(PIPE_LATENCY - 1)) begin
                    w_cnt_nxt = '0;
                    if (r_filter == BM_AW'(NUMBER_OF_FILTERS - 1)) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt  = LOAD_W;
                        w_filter_nxt = r_filter + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            DONE: begin
                w_done       = 1'b1;
                w_state_nxt  = IDLE;
                w_filter_nxt = '0;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // A tag is valid once a full KxK window has been shifted into the conv FIFO.
    always_comb begin
        w_row       = r_cnt / CNT_W'(IFM_SIZE);
        w_col       = r_cnt % CNT_W'(IFM_SIZE);
        w_tag_valid = (r_state == STREAM) &&
                      (w_row >= CNT_W'(KERNAL_SIZE - 1)) &&
                      (w_col >= CNT_W'(KERNAL_SIZE - 1));
        w_tag_addr  = '0;
        if (w_tag_valid) begin
            w_tag_addr = OFM_AW'((w_row - CNT_W'(KERNAL_SIZE - 1)) * CNT_W'(IFM_SIZE_NEXT) +
                                 (w_col - CNT_W'(KERNAL_SIZE - 1)));
        end
    end

    tag_delay_line #(
        .DEPTH (PIPE_LATENCY),
        .WIDTH (TAG_W)
    ) u_tag_delay (
        .clk     (clk),
        .i_clear (reset),
        .i_data  ({w_tag_valid, w_tag_addr}),
        .o_data  (w_dl_out)
    );

    assign w_dl_valid = w_dl_out[TAG_W-1];
    assign w_dl_addr  = w_dl_out[OFM_AW-1:0];

    assign bus.busy                     = w_busy;
    assign bus.done                     = w_done;
    assign bus.ifm_enable_read_current  = w_ifm_en;
    assign bus.ifm_address_read_current = w_ifm_addr;
    assign bus.fifo_enable              = r_fifo_en;
    assign bus.conv_enable              = r_fifo_en;
    assign bus.wm_addr_sel              = w_wm_en;
    assign bus.wm_enable_read           = w_wm_en;
    assign bus.wm_address_read_current  = w_wm_addr;
    assign bus.wm_fifo_enable           = r_wm_fifo_en;
    assign bus.bm_addr_sel              = w_busy;
    assign bus.bm_enable_read           = w_bm_en;
    assign bus.bm_address_read_current  = r_filter;
    assign bus.ofm_enable_write         = w_dl_valid ? (NUMBER_OF_FILTERS'(1) << r_filter) : '0;
    assign bus.ofm_address_write        = w_dl_addr;

endmodule

// File: tb/tb_conv_a1_controller.sv
// Directed self-checking bench for conv_a1_controller.
module tb_conv_a1_controller;
    import conv_a1_pkg::*;

    localparam int PER_FILTER = 25 + 1024 + 7;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    conv_a1_controller_if u_if ();

    conv_a1_controller u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [46:0] all_outs();
        return {u_if.busy, u_if.done, u_if.ifm_enable_read_current, u_if.ifm_address_read_current,
                u_if.fifo_enable, u_if.conv_enable, u_if.wm_addr_sel, u_if.wm_enable_read,
                u_if.wm_address_read_current, u_if.wm_fifo_enable, u_if.bm_addr_sel,
                u_if.bm_enable_read, u_if.bm_address_read_current, u_if.ofm_enable_write,
                u_if.ofm_address_write};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        u_if.start = 1'b1;
        step();
        step();
        n_cmp++;
        if (all_outs() !== 47'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h expected 0", all_outs());
        end
        reset = 1'b0;
        u_if.start = 1'b0;
        step();
        n_cmp++;
        if (u_if.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle_busy: got %b expected 0", u_if.busy);
        end
    endtask

    task automatic test_load_w();
        u_if.start = 1'b1;
        step();
        u_if.start = 1'b0;
        n_cmp++;
        if (u_if.busy !== 1'b1) begin
            n_err++;
            $display("FAIL start_busy: got %b expected 1", u_if.busy);
        end
        for (int k = 0; k < 25; k++) begin
            n_cmp++;
            if (u_if.wm_enable_read !== 1'b1 || u_if.wm_addr_sel !== 1'b1 ||
                u_if.wm_address_read_current !== 8'(k) || u_if.wm_fifo_enable !== (k > 0) ||
                u_if.bm_addr_sel !== 1'b1) begin
                n_err++;
                $display("FAIL load_w k=%0d: got en=%b sel=%b addr=%0d fifo=%b bmsel=%b expected 1 1 %0d %b 1",
                         k, u_if.wm_enable_read, u_if.wm_addr_sel, u_if.wm_address_read_current,
                         u_if.wm_fifo_enable, u_if.bm_addr_sel, k, k > 0);
            end
            step();
        end
        n_cmp++;
        if (u_if.wm_fifo_enable !== 1'b1 || u_if.wm_enable_read !== 1'b0 ||
            u_if.ifm_enable_read_current !== 1'b1 || u_if.fifo_enable !== 1'b0) begin
            n_err++;
            $display("FAIL stream0: got wmfifo=%b wmen=%b ifmen=%b fifo=%b expected 1 0 1 0",
                     u_if.wm_fifo_enable, u_if.wm_enable_read, u_if.ifm_enable_read_current,
                     u_if.fifo_enable);
        end
    endtask

    task automatic test_stream_filter0();
        int writes;
        int last_addr;
        int p, r, c;
        bit exp_v;
        writes = 0;
        last_addr = -1;
        for (int s = 0; s < 1031; s++) begin
            n_cmp++;
            if (u_if.ifm_enable_read_current !== (s < 1024) ||
                u_if.ifm_address_read_current !== ((s < 1024) ? 10'(s) : 10'd0) ||
                u_if.fifo_enable !== (s >= 1 && s <= 1024) ||
                u_if.conv_enable !== (s >= 1 && s <= 1024)) begin
                n_err++;
                $display("FAIL stream s=%0d: got ifmen=%b addr=%0d fifo=%b conv=%b", s,
                         u_if.ifm_enable_read_current, u_if.ifm_address_read_current,
                         u_if.fifo_enable, u_if.conv_enable);
            end
            p = s - 7;
            r = p / 32;
            c = p % 32;
            exp_v = (p >= 0) && (r >= 4) && (c >= 4);
            n_cmp++;
            if (u_if.ofm_enable_write !== (exp_v ? 6'b000001 : 6'b000000) ||
                (exp_v && u_if.ofm_address_write !== 10'((r - 4) * 28 + (c - 4)))) begin
                n_err++;
                $display("FAIL ofm_write s=%0d: got en=%b addr=%0d expected en=%b addr=%0d", s,
                         u_if.ofm_enable_write, u_if.ofm_address_write, exp_v,
                         (r - 4) * 28 + (c - 4));
            end
            if (s == 139) begin
                n_cmp++;
                if (u_if.ofm_enable_write !== 6'b000001 || u_if.ofm_address_write !== 10'd0) begin
                    n_err++;
                    $display("FAIL first_write: got en=%b addr=%0d expected 000001 0",
                             u_if.ofm_enable_write, u_if.ofm_address_write);
                end
            end
            if (u_if.ofm_enable_write !== 6'b0) begin
                writes++;
                last_addr = int'(u_if.ofm_address_write);
            end
            step();
        end
        n_cmp++;
        if (writes != 784 || last_addr != 783) begin
            n_err++;
            $display("FAIL filter0_writes: got count=%0d last=%0d expected 784 783", writes, last_addr);
        end
    endtask

    task automatic test_filter1_load();
        for (int k = 0; k < 25; k++) begin
            n_cmp++;
            if (u_if.wm_enable_read !== 1'b1 || u_if.wm_address_read_current !== 8'(25 + k) ||
                u_if.bm_address_read_current !== 3'd1 || u_if.ofm_enable_write !== 6'b0) begin
                n_err++;
                $display("FAIL filter1_load k=%0d: got en=%b wm=%0d bm=%0d ofm=%b expected 1 %0d 1 0",
                         k, u_if.wm_enable_read, u_if.wm_address_read_current,
                         u_if.bm_address_read_current, u_if.ofm_enable_write, 25 + k);
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            if (u_if.bm_address_read_current === 3'd2 && u_if.ifm_enable_read_current === 1'b1) begin
                found = 1'b1;
            end else begin
                step();
            end
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL reach_filter2_stream: got timeout expected STREAM of filter 2");
        end
        repeat (10) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++;
        if (all_outs() !== 47'd0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got %h expected 0", all_outs());
        end
        for (int i = 0; i < 20; i++) begin
            step();
            n_cmp++;
            if (u_if.done !== 1'b0 || u_if.busy !== 1'b0 || u_if.ofm_enable_write !== 6'b0) begin
                n_err++;
                $display("FAIL reset_mid_quiet i=%0d: got done=%b busy=%b ofm=%b expected 0 0 0",
                         i, u_if.done, u_if.busy, u_if.ofm_enable_write);
            end
        end
        u_if.start = 1'b1;
        step();
        u_if.start = 1'b0;
        n_cmp++;
        if (u_if.busy !== 1'b1 || u_if.wm_enable_read !== 1'b1 ||
            u_if.wm_address_read_current !== 8'd0 || u_if.bm_address_read_current !== 3'd0) begin
            n_err++;
            $display("FAIL restart: got busy=%b wmen=%b wm=%0d bm=%0d expected 1 1 0 0",
                     u_if.busy, u_if.wm_enable_read, u_if.wm_address_read_current,
                     u_if.bm_address_read_current);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic run_full(input bit inject, input string tag);
        int done_c;
        int done_n;
        int wr [6];
        int f_exp;
        bit finished;
        logic [5:0] exp_oh;
        done_c = -1;
        done_n = 0;
        finished = 1'b0;
        foreach (wr[i]) wr[i] = 0;
        u_if.start = 1'b1;
        step();
        u_if.start = 1'b0;
        for (int c = 0; c < 7000 && !finished; c++) begin
            f_exp = c / PER_FILTER;
            if (u_if.done === 1'b1) begin
                done_n++;
                done_c = c;
            end
            if (u_if.ofm_enable_write !== 6'b0) begin
                exp_oh = 6'b000001 << f_exp;
                n_cmp++;
                if (f_exp > 5 || u_if.ofm_enable_write !== exp_oh) begin
                    n_err++;
                    $display("FAIL %s onehot c=%0d: got %b expected %b", tag, c,
                             u_if.ofm_enable_write, exp_oh);
                end else begin
                    wr[f_exp]++;
                end
            end
            if (done_c >= 0 && c == done_c + 1) begin
                finished = 1'b1;
                n_cmp++;
                if (u_if.busy !== 1'b0 || u_if.done !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s return_idle: got busy=%b done=%b expected 0 0", tag,
                             u_if.busy, u_if.done);
                end
            end
            u_if.start = inject && (c == 500 || c == 3000 || c == 6336);
            step();
        end
        u_if.start = 1'b0;
        n_cmp++;
        if (done_n != 1 || done_c != 6 * PER_FILTER || !finished) begin
            n_err++;
            $display("FAIL %s done_timing: got pulses=%0d at=%0d expected 1 at %0d", tag,
                     done_n, done_c, 6 * PER_FILTER);
        end
        for (int f = 0; f < 6; f++) begin
            n_cmp++;
            if (wr[f] != 784) begin
                n_err++;
                $display("FAIL %s writes_f%0d: got %0d expected 784", tag, f, wr[f]);
            end
        end
    endtask

    task automatic test_full_run();
        run_full(1'b0, "full_run");
    endtask

    task automatic test_start_ignored();
        run_full(1'b1, "start_ignored");
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        u_if.start = 1'b0;
        step();
        test_reset();
        test_load_w();
        test_stream_filter0();
        test_filter1_load();
        test_reset_mid();
        test_full_run();
        test_start_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
